wash_phase_timer: RTL and testbench
===================================

# wash_phase_timer

Programmable phase-duration timer that sits directly beside the washing-machine cycle controller. It consumes the controller's `timer_enable` and `phase_sel`, counts the programmed duration of the active phase (soak/wash/rinse/spin) in prescaled ticks, and returns `timer_done` to advance the controller. It pauses while the lid is open or power is held, and exposes remaining time for display.

## Interface
- `CLK_PER_TICK`, default 1000: clk cycles per duration tick; must be ≥1.
- `CNT_W`, default 8: width of durations and `remaining`.
- `SOAK_T`, `WASH_T`, `RINSE_T`, `SPIN_T`, defaults 20, 30, 15, 10: reset durations in ticks for phases 0–3.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `timer_enable`  in  1  controller is in a timed phase.
- `phase_sel`  in  2  active phase: 0 soak, 1 wash, 2 rinse, 3 spin.
- `power_on`  in  1  counting allowed; also gates consumption of `timer_done`.
- `pause`  in  1  lid open; counting frozen.
- `cfg_we`  in  1  write strobe for duration register.
- `cfg_sel`  in  2  duration register index.
- `cfg_data`  in  CNT_W  duration value in ticks.
- `timer_done`  out  1  phase expired; held until consumed.
- `remaining`  out  CNT_W  ticks left in current phase.
- `running`  out  1  high in RUN state.
- `cur_phase`  out  2  phase captured at last load.

## Operation
- Duration regs `dur[0..3]` reset to `SOAK_T..SPIN_T`. When `cfg_we`=1, `dur[cfg_sel]<=cfg_data` at that edge. Writes are allowed in any state and affect only later loads, never the running count.
- Prescaler `pre` has width `max(1,$clog2(CLK_PER_TICK))`. A tick is `pre==CLK_PER_TICK-1` in a counting cycle. On a tick, `pre` wraps to 0.
- Counting cycle: state RUN, `timer_enable`=1, no reload, `power_on`=1 and `pause`=0. In a counting cycle without a tick, `pre` increments. Otherwise `pre` holds.
- Load: `remaining<=dur[phase_sel]`, `cur_phase<=phase_sel`, `pre<=0`. If the loaded duration is 0, the state goes to EXPIRED and `timer_done<=1` at the same edge. Otherwise the state goes to RUN.
- States and transitions, highest priority first in each state:
  - **IDLE**: `timer_enable`=1 → load.
  - **RUN**:
    - `timer_enable`=0 → IDLE; clear `remaining` and `pre`; no done.
    - `phase_sel!=cur_phase` → load.
    - Tick with `remaining==1` → `remaining<=0`, `timer_done<=1`, EXPIRED.
    - Tick otherwise → `remaining` decrements.
  - **EXPIRED**:
    - `timer_enable`=0 → IDLE.
    - `phase_sel!=cur_phase` → load.
    - Otherwise hold.
- `timer_done` clears at the first edge where it is 1 and `power_on`=1. If `power_on`=0, it stays high until power returns, so the controller cannot miss it. A new expiry at the clearing edge takes priority and sets it again.
- `remaining` never underflows. `cur_phase` holds its value in IDLE.

## Timing
- Reset values: state IDLE; `timer_done`=0, `remaining`=0, `running`=0, `cur_phase`=0, `pre`=0; `dur` regs at parameter values.
- Load occurs at the first edge where `timer_enable`=1 is sampled. With duration D≥1, the load at edge L, and no pause, `timer_done` rises at edge L+D·CLK_PER_TICK.
- Each non-counting cycle (pause, `power_on`=0) delays expiry by exactly one cycle.
- Handshake:
  - `timer_done` high across edge E with `power_on`=1: the controller advances at E and `timer_done` falls at E.
  - New `phase_sel` is visible after E, so the reload happens at E+1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-operation aborts immediately to reset values, including the `dur` regs.

## Test plan
Use CLK_PER_TICK=4, CNT_W=8, and durations 3/5/2/6.
- **Reset.** Assert `rst_n`=0 mid-RUN → all outputs 0 and state IDLE. After release, read back each phase's default duration through a load.
- **Basic run.** Enable with phase 0 at edge L → `remaining` steps 3,2,1,0 at L+4, L+8, L+12. `timer_done` rises at L+12 and falls one cycle later with `power_on`=1.
- **Pause.** Hold `pause`=1 for 5 cycles in phase 1 → `timer_done` at L+20+5. Also hold `power_on`=0 for 3 cycles → total delay 8 cycles.
- **Held done.** Drop `power_on` at the expiry edge and keep it low 6 cycles → `timer_done` stays high all 6 cycles. It falls at the first edge with `power_on`=1.
- **Zero and config.**
  - Write `dur[2]=0`, then change phase 1→2 → `timer_done` set at the reload edge.
  - Write `dur[0]=9` mid-RUN in phase 0 → current count is unaffected.
- **Abort and reload.**
  - Drop `timer_enable` mid-RUN → IDLE, `remaining`=0, no `timer_done` pulse.
  - Change phase 0→3 with `remaining`=2 → `remaining`=6 and `cur_phase`=3 at the next edge.

Source files
------------

// File: rtl/wash_phase_timer.sv
// ---------------------------------------------------------------------------
// wash_phase_timer
//
// Phase-duration timer for the washing-machine cycle controller. When the
// controller raises i_timer_enable, the duration of the selected phase is
// loaded and counted down in prescaled ticks. Expiry is reported on
// o_timer_done, which stays high until it is consumed on an edge with power.
// Counting is frozen while the lid is open (i_pause) or power is held off.
//
// Handshake: o_timer_done is a level. The controller consumes it at the
// first rising clk edge where o_timer_done=1 and i_power_on=1; o_timer_done
// falls at that same edge. The controller then presents the next
// i_phase_sel, and the timer reloads on the following edge.
//
// Ports
//   clk             clock
//   rst_n           asynchronous active-low reset (also restores durations)
//   i_timer_enable  controller is in a timed phase
//   i_phase_sel     active phase: 0 soak, 1 wash, 2 rinse, 3 spin
//   i_power_on      counting allowed; also gates consumption of done
//   i_pause         lid open, counting frozen
//   i_cfg_we        duration register write strobe
//   i_cfg_sel       duration register index
//   i_cfg_data      duration value in ticks
//   o_timer_done    phase expired, held until consumed
//   o_remaining     ticks left in the current phase
//   o_running       high while in RUN
//   o_cur_phase     phase captured at the last load
//   o_dbg_state     FSM state (0 IDLE, 1 RUN, 2 EXPIRED)
// ---------------------------------------------------------------------------
module wash_phase_timer #(
  parameter int CLK_PER_TICK = 1000,
  parameter int CNT_W        = 8,
  parameter int SOAK_T       = 20,
  parameter int WASH_T       = 30,
  parameter int RINSE_T      = 15,
  parameter int SPIN_T       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_timer_enable,
  input  logic [1:0]       i_phase_sel,
  input  logic             i_power_on,
  input  logic             i_pause,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_sel,
  input  logic [CNT_W-1:0] i_cfg_data,
  output logic             o_timer_done,
  output logic [CNT_W-1:0] o_remaining,
  output logic             o_running,
  output logic [1:0]       o_cur_phase,
  output logic [1:0]       o_dbg_state
);

  localparam int PRE_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_PER_TICK - 1);
  localparam logic [PRE_W-1:0] PRE_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [CNT_W-1:0] r_remaining;
  logic [1:0]       r_cur_phase;
  logic             r_done;
  logic             r_running;
  logic [CNT_W-1:0] r_dur [4];

  state_t           w_next_state;
  logic [PRE_W-1:0] w_next_pre;
  logic [CNT_W-1:0] w_next_rem;
  logic [1:0]       w_next_phase;
  logic             w_next_done;
  logic             w_expire;
  logic             w_load;
  logic [CNT_W-1:0] w_load_dur;
  logic             w_phase_chg;
  logic             w_counting;
  logic             w_tick;

  assign w_load_dur  = r_dur[i_phase_sel];
  assign w_phase_chg = (i_phase_sel != r_cur_phase);
  // A phase change in RUN is a reload, so that cycle never counts.
  assign w_counting  = (r_state == S_RUN) && i_timer_enable && !w_phase_chg &&
                       i_power_on && !i_pause;
  assign w_tick      = w_counting && (r_pre == PRE_MAX);

  // Next-state and datapath
  always_comb begin
    w_next_state = r_state;
    w_next_pre   = r_pre;
    w_next_rem   = r_remaining;
    w_next_phase = r_cur_phase;
    w_expire     = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_timer_enable) w_load = 1'b1;
      end
      S_RUN: begin
        if (!i_timer_enable) begin
          w_next_state = S_IDLE;
          w_next_rem   = CNT_ZERO;
          w_next_pre   = PRE_ZERO;
        end else if (w_phase_chg) begin
          w_load = 1'b1;
        end else if (w_tick) begin
          w_next_pre = PRE_ZERO;
          // <= guards against underflow even though RUN always holds >= 1.
          if (r_remaining <= CNT_ONE) begin
            w_next_rem   = CNT_ZERO;
            w_expire     = 1'b1;
            w_next_state = S_EXPIRED;
          end else begin
            w_next_rem = r_remaining - CNT_ONE;
          end
        end else if (w_counting) begin
          w_next_pre = r_pre + 1'b1;
        end
      end
      S_EXPIRED: begin
        if (!i_timer_enable) begin
          w_next_state = S_IDLE;
        end else if (w_phase_chg) begin
          w_load = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (w_load) begin
      w_next_rem   = w_load_dur;
      w_next_phase = i_phase_sel;
      w_next_pre   = PRE_ZERO;
      if (w_load_dur == CNT_ZERO) begin
        w_expire     = 1'b1;
        w_next_state = S_EXPIRED;
      end else begin
        w_next_state = S_RUN;
      end
    end
  end

  // Done is a sticky level: a fresh expiry wins over consumption.
  always_comb begin
    w_next_done = r_done;
    if (w_expire) begin
      w_next_done = 1'b1;
    end else if (r_done && i_power_on) begin
      w_next_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pre       <= PRE_ZERO;
      r_remaining <= CNT_ZERO;
      r_cur_phase <= 2'd0;
      r_done      <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pre       <= w_next_pre;
      r_remaining <= w_next_rem;
      r_cur_phase <= w_next_phase;
      r_done      <= w_next_done;
      r_running   <= (w_next_state == S_RUN);
    end
  end

  // Writes land after any same-edge load has read the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dur[0] <= CNT_W'(SOAK_T);
      r_dur[1] <= CNT_W'(WASH_T);
      r_dur[2] <= CNT_W'(RINSE_T);
      r_dur[3] <= CNT_W'(SPIN_T);
    end else if (i_cfg_we) begin
      r_dur[i_cfg_sel] <= i_cfg_data;
    end
  end

  assign o_timer_done = r_done;
  assign o_remaining  = r_remaining;
  assign o_running    = r_running;
  assign o_cur_phase  = r_cur_phase;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_wash_phase_timer.sv
// ---------------------------------------------------------------------------
// Testbench for wash_phase_timer (CLK_PER_TICK=4, durations 3/5/2/6).
// A cycle-level reference model pushes the expected output vector into
// exp_q as each cycle's stimulus is applied; after the edge it is popped and
// compared field by field. Directed scenarios add hand-derived checks on
// timing and values.
// ---------------------------------------------------------------------------
module tb_wash_phase_timer;

  localparam int CPT = 4;
  localparam int CW  = 8;
  localparam int W   = 14;  // {state[13:12], done, running, phase[9:8], rem[7:0]}

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_RUN  = 2'd1;
  localparam logic [1:0] M_EXP  = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          timer_enable, power_on, pause, cfg_we;
  logic [1:0]    phase_sel, cfg_sel;
  logic [CW-1:0] cfg_data;
  logic          o_done, o_running;
  logic [CW-1:0] o_rem;
  logic [1:0]    o_phase, o_state;

  wash_phase_timer #(
    .CLK_PER_TICK(CPT), .CNT_W(CW),
    .SOAK_T(3), .WASH_T(5), .RINSE_T(2), .SPIN_T(6)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_timer_enable(timer_enable), .i_phase_sel(phase_sel),
    .i_power_on(power_on), .i_pause(pause),
    .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_data(cfg_data),
    .o_timer_done(o_done), .o_remaining(o_rem), .o_running(o_running),
    .o_cur_phase(o_phase), .o_dbg_state(o_state)
  );

  int n_total = 0;
  int n_bad   = 0;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic [1:0]    m_state;
  logic [1:0]    m_pre;
  logic [CW-1:0] m_rem;
  logic [1:0]    m_phase;
  logic          m_done;
  logic [CW-1:0] m_dur [4];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_pre = 2'd0; m_rem = '0; m_phase = 2'd0; m_done = 1'b0;
    m_dur[0] = 8'd3; m_dur[1] = 8'd5; m_dur[2] = 8'd2; m_dur[3] = 8'd6;
  endtask

  task automatic model_load();
    m_rem   = m_dur[phase_sel];
    m_phase = phase_sel;
    m_pre   = 2'd0;
    m_state = (m_rem == 0) ? M_EXP : M_RUN;
  endtask

  // Computes the outputs expected after the coming edge from current inputs.
  task automatic model_step();
    logic expire;
    logic counting;
    logic was_done;
    expire   = 1'b0;
    was_done = m_done;
    counting = (m_state == M_RUN) && timer_enable && (phase_sel == m_phase) &&
               power_on && !pause;
    case (m_state)
      M_IDLE: if (timer_enable) begin model_load(); expire = (m_state == M_EXP); end
      M_RUN: begin
        if (!timer_enable) begin
          m_state = M_IDLE; m_rem = '0; m_pre = 2'd0;
        end else if (phase_sel != m_phase) begin
          model_load(); expire = (m_state == M_EXP);
        end else if (counting) begin
          if (m_pre == 2'(CPT - 1)) begin
            m_pre = 2'd0;
            if (m_rem == 1) begin m_rem = '0; expire = 1'b1; m_state = M_EXP; end
            else m_rem = m_rem - 1'b1;
          end else begin
            m_pre = m_pre + 1'b1;
          end
        end
      end
      default: begin
        if (!timer_enable) m_state = M_IDLE;
        else if (phase_sel != m_phase) begin model_load(); expire = (m_state == M_EXP); end
      end
    endcase
    if (expire) m_done = 1'b1;
    else if (was_done && power_on) m_done = 1'b0;
    if (cfg_we) m_dur[cfg_sel] = cfg_data;
    exp_q.push_back({m_state, m_done, (m_state == M_RUN), m_phase, m_rem});
  endtask

  // driver: one clock cycle with the currently driven inputs, then score.
  task automatic step();
    logic [W-1:0] e;
    model_step();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val("state",   o_state,   e[13:12]);
      check_val("done",    o_done,    e[11]);
      check_val("running", o_running, e[10]);
      check_val("phase",   o_phase,   e[9:8]);
      check_val("rem",     o_rem,     e[7:0]);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_done"},  o_done,    0);
    check_val({tag, "_rem"},   o_rem,     0);
    check_val({tag, "_run"},   o_running, 0);
    check_val({tag, "_phase"}, o_phase,   0);
    check_val({tag, "_state"}, o_state,   M_IDLE);
  endtask

  task automatic restart(input logic [1:0] p);
    timer_enable = 1'b0; step();
    phase_sel = p; timer_enable = 1'b1; step();
  endtask

  logic [CW-1:0] def_dur [4];
  int got;

  initial begin
    def_dur[0] = 8'd3; def_dur[1] = 8'd5; def_dur[2] = 8'd2; def_dur[3] = 8'd6;
    rst_n = 1'b0; timer_enable = 1'b0; phase_sel = 2'd0; power_on = 1'b1;
    pause = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // default durations read back through a load
    for (int p = 0; p < 4; p++) begin
      restart(2'(p));
      check_val("default_dur", o_rem, def_dur[p]);
      check_val("default_phase", o_phase, p);
    end

    // basic run: 3,2,1,0 at L+4, L+8, L+12; done L+12, cleared L+13
    restart(2'd0);
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k == 4)  check_val("basic_rem4", o_rem, 2);
      if (k == 8)  check_val("basic_rem8", o_rem, 1);
      if (k == 11) check_val("basic_done11", o_done, 0);
      if (k == 12) check_val("basic_done12", o_done, 1);
      if (k == 12) check_val("basic_rem12", o_rem, 0);
      if (k == 13) check_val("basic_done13", o_done, 0);
    end

    // pause 5 cycles plus power off 3 cycles in wash: done at L+20+8
    restart(2'd1);
    got = -1;
    for (int k = 1; k <= 60 && got < 0; k++) begin
      pause    = (k <= 5);
      power_on = !(k >= 6 && k <= 8);
      step();
      if (o_done) got = k;
    end
    pause = 1'b0; power_on = 1'b1;
    check_val("pause_delay", got, 28);
    step();

    // held done: power off after the expiry edge for 6 cycles
    restart(2'd2);
    for (int k = 1; k <= 8; k++) step();
    check_val("held_rise", o_done, 1);
    power_on = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("held_high", o_done, 1);
    end
    power_on = 1'b1;
    step();
    check_val("held_clear", o_done, 0);

    // zero duration: dur[2]=0 then phase 1 -> 2 expires at the reload edge
    restart(2'd1);
    repeat (3) step();
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 8'd0;
    step();
    cfg_we = 1'b0;
    phase_sel = 2'd2;
    step();
    check_val("zero_done", o_done, 1);
    check_val("zero_state", o_state, M_EXP);
    check_val("zero_phase", o_phase, 2);
    step();

    // dur[0]=9 written mid-run does not touch the live count
    restart(2'd0);
    for (int k = 1; k <= 12; k++) begin
      cfg_we = (k == 2); cfg_sel = 2'd0; cfg_data = 8'd9;
      step();
      if (k == 4) check_val("cfg_live_rem", o_rem, 2);
    end
    cfg_we = 1'b0;
    check_val("cfg_live_done", o_done, 1);
    restart(2'd0);
    check_val("cfg_new_load", o_rem, 9);

    // abort mid-run: no done pulse; also put dur[0] back to 3
    repeat (5) step();
    timer_enable = 1'b0; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd3;
    step();
    cfg_we = 1'b0;
    check_val("abort_rem", o_rem, 0);
    check_val("abort_state", o_state, M_IDLE);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("abort_no_done", o_done, 0);
    end

    // phase 0 -> 3 with remaining 2 reloads spin duration
    phase_sel = 2'd0; timer_enable = 1'b1; step();
    repeat (4) step();
    check_val("swap_rem_before", o_rem, 2);
    phase_sel = 2'd3;
    step();
    check_val("swap_rem", o_rem, 6);
    check_val("swap_phase", o_phase, 3);

    // random traffic scored by the model
    for (int k = 0; k < 400; k++) begin
      timer_enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 14) == 0) phase_sel = 2'($urandom_range(0, 3));
      pause    = ($urandom_range(0, 5) == 0);
      power_on = ($urandom_range(0, 7) != 0);
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_sel  = 2'($urandom_range(0, 3));
      cfg_data = 8'($urandom_range(0, 7));
      step();
    end
    pause = 1'b0; power_on = 1'b1; cfg_we = 1'b0;

    // reset mid-run restores defaults
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 8'd9;
    restart(2'd0);
    cfg_we = 1'b0;
    restart(2'd0);
    repeat (3) step();
    check_val("prereset_running", o_running, 1);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(posedge clk); #1;
    check_zero("reset_hold");
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      restart(2'(p));
      check_val("post_reset_dur", o_rem, def_dur[p]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
